// File: rtl/mem_read_responder_if.sv
// Read-channel bundle between a burst-read master and mem_read_responder.
// AR carries (addr, len) requests; R returns address-patterned data beats.
interface mem_read_responder_if #(
  parameter int ADDR_BITS       = 64,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int DATA_BITS       = 512
);
  logic                       ar_valid;
  logic                       ar_ready;
  logic [ADDR_BITS-1:0]       ar_addr;
  logic [BURST_LEN_WIDTH-1:0] ar_len;
  logic                       r_valid;
  logic                       r_ready;
  logic [DATA_BITS-1:0]       r_data;
  logic                       r_last;

  modport master (
    output ar_valid, ar_addr, ar_len, r_ready,
    input  ar_ready, r_valid, r_data, r_last
  );

  modport slave (
    input  ar_valid, ar_addr, ar_len, r_ready,
    output ar_ready, r_valid, r_data, r_last
  );
endinterface

// File: rtl/mem_read_responder.sv
// Memory read responder: queues AR requests in a circular FIFO and replays each
// as a burst whose beat data is the beat address replicated over the data bus.
module mem_read_responder #(
  parameter int LOG_QUEUE_SIZE       = 2,
  parameter int LOG_BLOCK_DATA_BYTES = 6,
  parameter int ADDR_BITS            = 64,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int LATENCY_WIDTH        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  mem_read_responder_if.slave       bus,
  input  logic [LATENCY_WIDTH-1:0]  crs_latency,
  output logic [LOG_QUEUE_SIZE:0]   outstandingCnt
);
  localparam int DEPTH     = 1 << LOG_QUEUE_SIZE;
  localparam int DATA_BITS = 8 << LOG_BLOCK_DATA_BYTES;
  // Data width is assumed to be a whole multiple of the address width.
  localparam int REP       = DATA_BITS / ADDR_BITS;
  localparam logic [LOG_QUEUE_SIZE:0]  DEPTH_CNT  = (LOG_QUEUE_SIZE+1)'(DEPTH);
  localparam logic [ADDR_BITS-1:0]     BEAT_BYTES = ADDR_BITS'(1) << LOG_BLOCK_DATA_BYTES;
  localparam logic [BURST_LEN_WIDTH-1:0] ONE_BEAT = BURST_LEN_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  logic [ADDR_BITS-1:0]       addrQ [DEPTH];
  logic [BURST_LEN_WIDTH-1:0] lenQ  [DEPTH];
  logic [LOG_QUEUE_SIZE-1:0]  head, tail;

  state_t                     state;
  logic [ADDR_BITS-1:0]       beatAddr;
  logic [BURST_LEN_WIDTH-1:0] curLen;
  logic [BURST_LEN_WIDTH-1:0] beatCnt;
  logic [LATENCY_WIDTH-1:0]   waitCnt;
  logic                       rValid, rLast;

  logic arReady, push, pop;

  // Readiness looks only at the registered count, so a full queue never
  // accepts in the same cycle as a pop.
  assign arReady = (outstandingCnt < DEPTH_CNT);
  assign push    = bus.ar_valid && arReady;
  assign pop     = rValid && bus.r_ready && rLast;

  assign bus.ar_ready = arReady;
  assign bus.r_valid  = rValid;
  assign bus.r_last   = rLast;
  assign bus.r_data   = {REP{beatAddr}};

  always_ff @(posedge clk) begin
    if (push) begin
      addrQ[tail] <= bus.ar_addr;
      lenQ[tail]  <= bus.ar_len;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head           <= '0;
      tail           <= '0;
      outstandingCnt <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   outstandingCnt <= outstandingCnt + 1'b1;
        2'b01:   outstandingCnt <= outstandingCnt - 1'b1;
        default: outstandingCnt <= outstandingCnt;
      endcase
    end
  end

  // The head entry stays queued until its last beat is accepted, so it is
  // counted as outstanding for the whole burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      beatAddr <= '0;
      curLen   <= '0;
      beatCnt  <= '0;
      waitCnt  <= '0;
      rValid   <= 1'b0;
      rLast    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (outstandingCnt != '0) begin
            state    <= WAIT;
            beatAddr <= addrQ[head];
            curLen   <= lenQ[head];
            beatCnt  <= '0;
            waitCnt  <= crs_latency;
          end
        end
        WAIT: begin
          if (waitCnt == '0) begin
            state  <= BURST;
            rValid <= 1'b1;
            rLast  <= (curLen == '0);
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        BURST: begin
          if (bus.r_ready) begin
            if (rLast) begin
              state  <= IDLE;
              rValid <= 1'b0;
              rLast  <= 1'b0;
            end else begin
              beatCnt  <= beatCnt + ONE_BEAT;
              beatAddr <= beatAddr + BEAT_BYTES;
              rLast    <= ((beatCnt + ONE_BEAT) == curLen);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_read_responder.sv
// Scoreboard bench for mem_read_responder: stimulus queues expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_mem_read_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  crs_latency;
  logic [2:0]  outstandingCnt;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [63:0] addr;
    logic        last;
  } beat_t;
  beat_t sb[$];

  mem_read_responder_if #(.ADDR_BITS(64), .BURST_LEN_WIDTH(8), .DATA_BITS(512)) bus ();

  mem_read_responder #(
    .LOG_QUEUE_SIZE(2), .LOG_BLOCK_DATA_BYTES(6), .ADDR_BITS(64),
    .BURST_LEN_WIDTH(8), .LATENCY_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .crs_latency(crs_latency), .outstandingCnt(outstandingCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expectBurst(input logic [63:0] addr, input logic [7:0] len);
    for (int unsigned i = 0; i <= 32'(len); i++) begin
      beat_t b;
      b.addr = addr + (64'(i) << 6);
      b.last = (i == 32'(len));
      sb.push_back(b);
    end
  endtask

  task automatic sendAr(input logic [63:0] addr, input logic [7:0] len);
    int k;
    expectBurst(addr, len);
    bus.ar_addr  = addr;
    bus.ar_len   = len;
    bus.ar_valid = 1'b1;
    k = 0;
    while (!bus.ar_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.ar_ready) begin
      checks++; fails++;
      $display("FAIL arTimeout: ar_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1 bus.ar_valid = 1'b0;
  endtask

  task automatic waitFirst(input int expN, input string name, input bit changeLat);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (changeLat && n == 2) crs_latency = 4'd0;
      if (bus.r_valid) break;
    end
    chk(name, 64'(n), 64'(expN));
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (k < 400 && !(sb.size() == 0 && outstandingCnt == 3'd0 && !bus.r_valid)) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 400) begin
      fails++;
      $display("FAIL %s: drain timeout, %0d beats left, outstandingCnt=%0d required 0",
               name, sb.size(), outstandingCnt);
    end
  endtask

  // Monitor: compares each accepted beat against the scoreboard and checks
  // that a stalled beat is held unchanged.
  initial begin
    logic         prevStall;
    logic [511:0] prevData;
    logic         prevLast;
    prevStall = 1'b0;
    prevData  = '0;
    prevLast  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          checks++;
          if (!bus.r_valid || bus.r_data !== prevData || bus.r_last !== prevLast) begin
            fails++;
            $display("FAIL holdStable: valid=%0b last=%0b data changed=%0b, required valid=1 last=%0b unchanged",
                     bus.r_valid, bus.r_last, bus.r_data !== prevData, prevLast);
          end
        end
        if (bus.r_valid && bus.r_ready) begin
          checks++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpectedBeat: data lane0=0x%0h last=%0b, required no beat",
                     bus.r_data[63:0], bus.r_last);
          end else begin
            beat_t        e;
            logic [511:0] expData;
            e = sb.pop_front();
            expData = {8{e.addr}};
            if (bus.r_data !== expData || bus.r_last !== e.last) begin
              fails++;
              $display("FAIL beat: data=0x%0h last=%0b, required data=0x%0h last=%0b",
                       bus.r_data, bus.r_last, expData, e.last);
            end
          end
        end
        prevStall = bus.r_valid && !bus.r_ready;
        prevData  = bus.r_data;
        prevLast  = bus.r_last;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  popNeg;
    bit  popSeen;
    reset        = 1'b1;
    crs_latency  = 4'd0;
    bus.ar_valid = 1'b0;
    bus.ar_addr  = '0;
    bus.ar_len   = '0;
    bus.r_ready  = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rstRValid", 64'(bus.r_valid), 64'd0);
    chk("rstRLast",  64'(bus.r_last),  64'd0);
    chk("rstRData",  64'(bus.r_data == '0), 64'd1);
    chk("rstCnt",    64'(outstandingCnt), 64'd0);
    chk("rstArReady", 64'(bus.ar_ready), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Single beat, zero latency
    crs_latency = 4'd0;
    sendAr(64'h1000, 8'd0);
    waitFirst(3, "latSingle", 1'b0);
    chk("singleLast", 64'(bus.r_last), 64'd1);
    drain("single");
    chk("singleCnt", 64'(outstandingCnt), 64'd0);

    // Four-beat burst, latency 5; latency input changed mid-wait must be ignored
    crs_latency = 4'd5;
    sendAr(64'h40, 8'd3);
    waitFirst(8, "latBurst5", 1'b1);
    drain("burst");

    // Backpressure mid-burst
    crs_latency = 4'd0;
    sendAr(64'h200, 8'd3);
    waitFirst(3, "latBp", 1'b0);
    @(posedge clk);
    #1 bus.r_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.r_ready = 1'b1;
    drain("backpressure");

    // Full queue with stalled R channel
    bus.r_ready = 1'b0;
    sendAr(64'h1000, 8'd1);
    sendAr(64'h2000, 8'd0);
    sendAr(64'h3000, 8'd2);
    sendAr(64'h4000, 8'd0);
    chk("fullArReady", 64'(bus.ar_ready), 64'd0);
    chk("fullCnt", 64'(outstandingCnt), 64'd4);
    expectBurst(64'h5000, 8'd1);
    bus.ar_addr  = 64'h5000;
    bus.ar_len   = 8'd1;
    bus.ar_valid = 1'b1;
    bus.r_ready  = 1'b1;
    popSeen = 1'b0;
    popNeg  = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!popSeen && bus.r_valid && bus.r_ready && bus.r_last) begin
        chk("fullNoPushOnPop", 64'(bus.ar_ready), 64'd0);
        popSeen = 1'b1;
        popNeg  = n;
      end else if (bus.ar_ready) begin
        chk("fullReadyAfterPop", 64'(popSeen && n == popNeg + 1), 64'd1);
        break;
      end
    end
    chk("fifthAccepted", 64'(bus.ar_ready), 64'd1);
    @(posedge clk);
    #1 bus.ar_valid = 1'b0;
    drain("fullQueue");

    // Address wrap at the top of the address space
    crs_latency = 4'd2;
    sendAr(64'hFFFF_FFFF_FFFF_FFC0, 8'd1);
    waitFirst(5, "latWrap", 1'b0);
    drain("wrap");

    // Maximum-length burst: 256 beats
    crs_latency = 4'd1;
    sendAr(64'h0, 8'd255);
    waitFirst(4, "latLong", 1'b0);
    drain("longBurst");

    // Reset during the second of four beats
    crs_latency = 4'd0;
    sendAr(64'h3000, 8'd3);
    waitFirst(3, "latRst", 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    #1;
    chk("rstMidRValid", 64'(bus.r_valid), 64'd0);
    chk("rstMidCnt", 64'(outstandingCnt), 64'd0);
    chk("rstMidArReady", 64'(bus.ar_ready), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("postRstCnt", 64'(outstandingCnt), 64'd0);
    chk("postRstRValid", 64'(bus.r_valid), 64'd0);

    chk("sbEmpty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
